// File: rtl/song_sequencer.sv
// Song ROM sequencer with live-key preemption; drives the tone generator's note bus.
// Optional `define SONG_LOOP_EN: the song wraps to address 0 instead of returning to IDLE.
`timescale 1ns/1ps
module song_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DUR_W     = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              live_valid,
  input  logic [7:0]        live_note,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8+DUR_W-1:0] rom_data,
  output logic [7:0]        note_out,
  output logic              note_stb,
  output logic              busy,
  output logic              src
);

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [DUR_W-1:0]  dur_cnt, dur_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [7:0]        song_note, song_note_n, note_n;
  logic              live_act, step, wrap, busy_n, src_n;

  assign live_act = live_valid && (live_note != 8'd0);
  assign rom_addr = ptr;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n     = state;
    ptr_n       = ptr;
    dur_n       = dur_cnt;
    gap_n       = gap_cnt;
    song_note_n = song_note;
    step        = 1'b0;
    wrap        = 1'b0;

    case (state)
      IDLE:  ;
      FETCH: state_n = LOAD;
      LOAD: begin
        if (rom_data[8 +: DUR_W] == '0) begin
          song_note_n = 8'd0;
          wrap        = 1'b1;
        end else begin
          song_note_n = rom_data[7:0];
          dur_n       = rom_data[8 +: DUR_W];
          state_n     = PLAY;
        end
      end
      PLAY: begin
        if (tick && !live_act) begin
          dur_n = dur_cnt - DUR_W'(1);
          if (dur_cnt == DUR_W'(1)) begin
            if (GAP_TICKS > 0) begin
              state_n     = GAP;
              gap_n       = GAP_W'(GAP_TICKS);
              song_note_n = 8'd0;
            end else begin
              step = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (tick && !live_act) begin
          gap_n = gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) step = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // The last ROM address ends the song exactly like an end marker.
    if (step) begin
      if (ptr == '1) begin
        wrap = 1'b1;
      end else begin
        ptr_n   = ptr + ADDR_W'(1);
        state_n = FETCH;
      end
    end

    if (wrap) begin
      ptr_n = '0;
`ifdef SONG_LOOP_EN
      state_n = FETCH;
`else
      state_n     = IDLE;
      song_note_n = 8'd0;
`endif
    end

    if (play_start) begin
      state_n = FETCH;
      ptr_n   = '0;
    end
    if (play_stop) begin
      state_n     = IDLE;
      ptr_n       = '0;
      song_note_n = 8'd0;
    end

    busy_n = (state_n != IDLE);
    src_n  = busy_n && !live_act;
    note_n = live_act ? live_note : song_note_n;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      song_note <= 8'd0;
      note_out  <= 8'd0;
      note_stb  <= 1'b0;
      busy      <= 1'b0;
      src       <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      dur_cnt   <= dur_n;
      gap_cnt   <= gap_n;
      song_note <= song_note_n;
      note_out  <= note_n;
      note_stb  <= (note_n != note_out);
      busy      <= busy_n;
      src       <= src_n;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: dut 0 uses defaults (GAP_TICKS=1), dut 1 uses ADDR_W=2, GAP_TICKS=0.
`timescale 1ns/1ps
module tb_song_sequencer;

  typedef struct {
    logic [7:0] note;
    int         ticks;   // ticks the note must be held; -1 = not checked
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start0 = 1'b0, stop0 = 1'b0, live_valid0 = 1'b0;
  logic [7:0] live_note0 = 8'h00;
  logic       start1 = 1'b0, stop1 = 1'b0;
  logic [7:0] rom_addr0;
  logic [1:0] rom_addr1;
  logic [11:0] rom_data0, rom_data1;
  logic [11:0] rom0 [4];
  logic [11:0] rom1 [4];
  logic [7:0] note_o [2];
  logic       stb_o [2];
  logic       busy_o [2];
  logic       src_o [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   tcount [2] = '{0, 0};
  int   prev_t [2] = '{-1, -1};
  int   errors = 0;
  int   checks = 0;
  int   tphase = 0;

  song_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .play_start(start0), .play_stop(stop0),
    .live_valid(live_valid0), .live_note(live_note0), .rom_addr(rom_addr0),
    .rom_data(rom_data0), .note_out(note_o[0]), .note_stb(stb_o[0]),
    .busy(busy_o[0]), .src(src_o[0])
  );

  song_sequencer #(.ADDR_W(2), .DUR_W(4), .GAP_TICKS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .play_start(start1), .play_stop(stop1),
    .live_valid(1'b0), .live_note(8'h00), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .note_out(note_o[1]), .note_stb(stb_o[1]),
    .busy(busy_o[1]), .src(src_o[1])
  );

  // Beat tick every 4 clocks, changed just after the edge.
  always @(posedge clk) begin
    #1;
    tick = (tphase == 0);
    tphase = (tphase + 1) % 4;
  end

  always @(posedge clk) begin
    rom_data0 <= rom0[rom_addr0[1:0]];
    rom_data1 <= rom1[rom_addr1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic push(input int d, input logic [7:0] n, input int t);
    exp_t e;
    e.note  = n;
    e.ticks = t;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic mon(input int d, input logic [7:0] n, input logic s);
    exp_t e;
    if (s) begin
      if (qsize(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe%0d: unexpected change to %0h at %0t", d, n, $time);
      end else begin
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check($sformatf("note%0d", d), 32'(n), 32'(e.note));
        if (prev_t[d] >= 0) check($sformatf("hold_ticks%0d", d), tcount[d], prev_t[d]);
        prev_t[d] = e.ticks;
      end
      tcount[d] = 0;
    end
    if (tick) tcount[d]++;
  endtask

  always @(negedge clk) begin
    mon(0, note_o[0], stb_o[0]);
    mon(1, note_o[1], stb_o[1]);
  end

  task automatic pulse_start(input int d);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_note(input int d, input logic [7:0] v);
    int g = 0;
    while (note_o[d] !== v && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) timeout($sformatf("wait_note%0d_%0h", d, v));
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    while (seen < n) begin
      if (tick) seen++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drained(input int d);
    int g = 0;
    while (qsize(d) != 0 && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (g >= 600) timeout($sformatf("drain%0d", d));
  endtask

  task automatic wait_idle(input int d);
    int g = 0;
    while (busy_o[d] !== 1'b0 && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (g >= 600) timeout($sformatf("idle%0d", d));
  endtask

  task automatic load_song1();
    rom0[0] = 12'h21A;
    rom0[1] = 12'h12C;
    rom0[2] = 12'h000;
    rom0[3] = 12'h000;
  endtask

  initial begin
    load_song1();
    rom1[0] = 12'h11A;
    rom1[1] = 12'h21A;
    rom1[2] = 12'h12C;
    rom1[3] = 12'h13E;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_note%0d", d), 32'(note_o[d]), 32'h0);
      check($sformatf("rst_busy%0d", d), 32'(busy_o[d]), 32'h0);
      check($sformatf("rst_src%0d", d), 32'(src_o[d]), 32'h0);
      check($sformatf("rst_stb%0d", d), 32'(stb_o[d]), 32'h0);
    end
    check("rst_addr0", 32'(rom_addr0), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two notes with a one-tick rest after each, then the end marker.
    push(0, 8'h1A, 2); push(0, 8'h00, 1); push(0, 8'h2C, 1); push(0, 8'h00, -1);
    pulse_start(0);
    wait_note(0, 8'h1A);
    check("play_busy", 32'(busy_o[0]), 32'h1);
    check("play_src", 32'(src_o[0]), 32'h1);
    wait_idle(0);
    check("end_note", 32'(note_o[0]), 32'h0);
    check("end_src", 32'(src_o[0]), 32'h0);
    wait_drained(0);

    // Live key preempts a 4-tick note after 2 ticks; 2 ticks remain after release.
    rom0[0] = 12'h41A;
    rom0[1] = 12'h000;
    push(0, 8'h1A, 2); push(0, 8'h30, -1); push(0, 8'h1A, 2); push(0, 8'h00, -1);
    pulse_start(0);
    wait_note(0, 8'h1A);
    wait_ticks(2);
    live_valid0 = 1'b1;
    live_note0  = 8'h30;
    @(negedge clk);
    check("live_note", 32'(note_o[0]), 32'h30);
    check("live_src", 32'(src_o[0]), 32'h0);
    check("live_busy", 32'(busy_o[0]), 32'h1);
    wait_ticks(3);
    live_valid0 = 1'b0;
    live_note0  = 8'h00;
    @(negedge clk);
    check("release_note", 32'(note_o[0]), 32'h1A);
    check("release_src", 32'(src_o[0]), 32'h1);
    wait_idle(0);
    wait_drained(0);

    // play_stop and play_start together mid-note: stop wins.
    load_song1();
    push(0, 8'h1A, 1); push(0, 8'h00, -1);
    pulse_start(0);
    wait_note(0, 8'h1A);
    wait_ticks(1);
    stop0  = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    stop0  = 1'b0;
    start0 = 1'b0;
    check("stop_note", 32'(note_o[0]), 32'h0);
    check("stop_busy", 32'(busy_o[0]), 32'h0);
    repeat (4) @(negedge clk);
    check("stop_stays_idle", 32'(busy_o[0]), 32'h0);
    wait_drained(0);

    // Reset during the rest after the second note (ptr=1).
    push(0, 8'h1A, 2); push(0, 8'h00, 1); push(0, 8'h2C, 1); push(0, 8'h00, -1);
    pulse_start(0);
    wait_note(0, 8'h2C);
    wait_ticks(1);
    check("gap_busy", 32'(busy_o[0]), 32'h1);
    check("gap_addr", 32'(rom_addr0), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_note", 32'(note_o[0]), 32'h0);
    check("mid_rst_stb", 32'(stb_o[0]), 32'h0);
    check("mid_rst_busy", 32'(busy_o[0]), 32'h0);
    check("mid_rst_src", 32'(src_o[0]), 32'h0);
    check("mid_rst_addr", 32'(rom_addr0), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_idle", 32'(busy_o[0]), 32'h0);
    wait_drained(0);

    // Legato repeat of 0x1A (one strobe) and end at the last ROM address.
    push(1, 8'h1A, 3); push(1, 8'h2C, 1); push(1, 8'h3E, 1);
`ifdef SONG_LOOP_EN
    push(1, 8'h1A, -1);
    pulse_start(1);
    wait_drained(1);
    check("loop_busy", 32'(busy_o[1]), 32'h1);
    check("loop_addr", 32'(rom_addr1), 32'h0);
    push(1, 8'h00, -1);
    stop1 = 1'b1;
    @(negedge clk);
    stop1 = 1'b0;
    wait_drained(1);
    check("loop_stop_busy", 32'(busy_o[1]), 32'h0);
`else
    push(1, 8'h00, -1);
    pulse_start(1);
    wait_drained(1);
    repeat (3) @(negedge clk);
    check("max_addr_busy", 32'(busy_o[1]), 32'h0);
    check("max_addr_src", 32'(src_o[1]), 32'h0);
    check("max_addr_note", 32'(note_o[1]), 32'h0);
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
